// File: rtl/fetch_queue_unit_if.sv
// Fetch queue unit bus: memory request/response, redirect input and decoder handshake.
// master = fetch unit side, slave = surrounding mem_ctrl / branch unit / decoder.
interface fetch_queue_unit_if #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned INST_W      = 32,
    parameter int unsigned QUEUE_DEPTH = 4
);
    localparam int unsigned CW = $clog2(QUEUE_DEPTH) + 1;

    logic [1:0]        mem_rw_flag;
    logic [ADDR_W-1:0] mem_addr;
    logic [1:0]        mem_len;
    logic [INST_W-1:0] mem_read_data;
    logic              mem_busy;
    logic              mem_done;
    logic              redirect_valid;
    logic              redirect_rel;
    logic [ADDR_W-1:0] redirect_addr;
    logic              dec_valid;
    logic              dec_ready;
    logic [ADDR_W-1:0] dec_pc;
    logic [INST_W-1:0] dec_inst;
    logic [CW-1:0]     q_count;

    modport master (
        output mem_rw_flag, mem_addr, mem_len, dec_valid, dec_pc, dec_inst, q_count,
        input  mem_read_data, mem_busy, mem_done,
        input  redirect_valid, redirect_rel, redirect_addr, dec_ready
    );

    modport slave (
        input  mem_rw_flag, mem_addr, mem_len, dec_valid, dec_pc, dec_inst, q_count,
        output mem_read_data, mem_busy, mem_done,
        output redirect_valid, redirect_rel, redirect_addr, dec_ready
    );
endinterface

// File: rtl/fetch_queue_unit.sv
// Instruction fetch unit: one outstanding sequential read, QUEUE_DEPTH-entry instruction FIFO,
// redirect with queue flush and stale-response discard, optional stop after control flow.
module fetch_queue_unit #(
    parameter int unsigned       ADDR_W       = 32,
    parameter int unsigned       INST_W       = 32,
    parameter int unsigned       QUEUE_DEPTH  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0,
    parameter bit                STOP_ON_CTRL = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    fetch_queue_unit_if.master bus
);
    localparam int unsigned   PW      = $clog2(QUEUE_DEPTH);
    localparam int unsigned   CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] fetch_pc, fetch_pc_n;
    logic [ADDR_W-1:0] last_ctrl_pc, last_ctrl_pc_n;
    logic [ADDR_W-1:0] req_addr;
    logic [ADDR_W-1:0] target;
    logic              discard, discard_n;
    logic              issue;
    logic              enq;
    logic              deq;
    logic              is_ctrl;
    logic              head_valid;
    logic [1:0]        rw_flag;
    logic [PW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count, count_post;
    logic [ADDR_W-1:0] pc_q   [QUEUE_DEPTH];
    logic [INST_W-1:0] inst_q [QUEUE_DEPTH];

    assign head_valid = (count != '0);
    assign is_ctrl    = bus.mem_read_data[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111};
    assign target     = bus.redirect_rel ? (last_ctrl_pc + bus.redirect_addr) : bus.redirect_addr;
    assign deq        = head_valid && bus.dec_ready && !bus.redirect_valid;
    // occupancy after the enqueue of the response being accepted this cycle
    assign count_post = count + CW'(1) - CW'(deq);

    always_comb begin
        state_n        = state;
        fetch_pc_n     = fetch_pc;
        last_ctrl_pc_n = last_ctrl_pc;
        discard_n      = discard;
        issue          = 1'b0;
        enq            = 1'b0;
        if (bus.redirect_valid) begin
            fetch_pc_n = target;
            // an unanswered request must have its response thrown away when it arrives
            if (state == WAIT && !bus.mem_done) begin
                discard_n = 1'b1;
                state_n   = WAIT;
            end else begin
                discard_n = 1'b0;
                state_n   = IDLE;
            end
        end else begin
            unique case (state)
                IDLE: begin
                    if (!bus.mem_busy && count < DEPTH_C) begin
                        issue   = 1'b1;
                        state_n = WAIT;
                    end
                end
                WAIT: begin
                    if (bus.mem_done) begin
                        if (discard) begin
                            discard_n = 1'b0;
                            state_n   = IDLE;
                        end else begin
                            enq = 1'b1;
                            if (is_ctrl) last_ctrl_pc_n = req_addr;
                            if (STOP_ON_CTRL && is_ctrl) begin
                                state_n = HOLD;
                            end else if (!bus.mem_busy && count_post < DEPTH_C) begin
                                issue   = 1'b1;
                                state_n = WAIT;
                            end else begin
                                state_n = IDLE;
                            end
                        end
                    end
                end
                HOLD: state_n = HOLD;
                default: state_n = IDLE;
            endcase
        end
        if (issue) fetch_pc_n = fetch_pc + ADDR_W'(4);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            fetch_pc     <= RESET_PC;
            last_ctrl_pc <= '0;
            discard      <= 1'b0;
            rw_flag      <= '0;
            req_addr     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
        end else begin
            state        <= state_n;
            fetch_pc     <= fetch_pc_n;
            last_ctrl_pc <= last_ctrl_pc_n;
            discard      <= discard_n;
            rw_flag      <= {1'b0, issue};
            if (issue) req_addr <= fetch_pc;
            if (bus.redirect_valid) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (enq) wr_ptr <= wr_ptr + PW'(1);
                if (deq) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(enq) - CW'(deq);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_q[wr_ptr]   <= req_addr;
            inst_q[wr_ptr] <= bus.mem_read_data;
        end
    end

    assign bus.mem_rw_flag = rw_flag;
    assign bus.mem_addr    = req_addr;
    assign bus.mem_len     = 2'b11;
    assign bus.dec_valid   = head_valid;
    assign bus.dec_pc      = head_valid ? pc_q[rd_ptr] : '0;
    assign bus.dec_inst    = head_valid ? inst_q[rd_ptr] : '0;
    assign bus.q_count     = count;
endmodule

// File: tb/tb_fetch_queue_unit.sv
// Self-checking bench for fetch_queue_unit: memory responder with 1-cycle latency,
// fetch-address model and a scoreboard of instructions expected at the decoder.
module tb_fetch_queue_unit;
    localparam int unsigned AW = 32;
    localparam int unsigned IW = 32;
    localparam int unsigned QD = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_queue_unit_if #(.ADDR_W(AW), .INST_W(IW), .QUEUE_DEPTH(QD)) bus ();

    fetch_queue_unit #(
        .ADDR_W(AW), .INST_W(IW), .QUEUE_DEPTH(QD), .RESET_PC(32'h0), .STOP_ON_CTRL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    int unsigned req_count, redir_count;
    logic [63:0] sb[$];
    logic [31:0] exp_pc, model_ctrl_pc, pend_addr, post_addr, arm_addr, drv_raddr, ctrl_at;
    logic pending, stale, hold, catch_next, arm_req, arm_done;
    logic drv_redir, drv_rel, drv_ready, drv_busy, ctrl_en;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] inst_at(input logic [31:0] a);
        if (ctrl_en && a == ctrl_at) return 32'h0000006F;
        return {a[24:0], 7'b0010011};
    endfunction

    function automatic logic is_ctrl_op(input logic [31:0] i);
        return i[6:0] inside {7'b1100011, 7'b1101111, 7'b1100111, 7'b0010111};
    endfunction

    task automatic model_reset();
        sb.delete();
        exp_pc = 32'h0; model_ctrl_pc = 32'h0; pend_addr = 32'h0;
        pending = 0; stale = 0; hold = 0; catch_next = 0; arm_req = 0; arm_done = 0;
        drv_redir = 0; req_count = 0; redir_count = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        bus.mem_done = 0; bus.mem_read_data = '0; bus.mem_busy = drv_busy;
        bus.redirect_valid = 0; bus.redirect_rel = 0; bus.redirect_addr = '0;
        bus.dec_ready = drv_ready;
        repeat (2) @(negedge clk);
        check("rst_rw", 64'(bus.mem_rw_flag), 64'(0));
        check("rst_addr", 64'(bus.mem_addr), 64'(0));
        check("rst_dec", {31'(0), bus.dec_valid, bus.dec_pc}, 64'(0));
        check("rst_inst", 64'(bus.dec_inst), 64'(0));
        check("rst_count", 64'(bus.q_count), 64'(0));
        rst_n = 1'b1;
    endtask

    // One clock: observe at the falling edge, then drive inputs for the next rising edge.
    task automatic cycle();
        logic        new_req, r, done_now;
        logic [31:0] req_a, target, d;
        logic [63:0] head;
        @(negedge clk);
        check("q_count", 64'(bus.q_count), 64'(sb.size()));
        check("dec_valid", 64'(bus.dec_valid), 64'(sb.size() != 0));
        check("rw_hi", 64'(bus.mem_rw_flag[1]), 64'(0));
        if (bus.dec_valid && sb.size() != 0) check("head", {bus.dec_pc, bus.dec_inst}, sb[0]);

        new_req = bus.mem_rw_flag[0];
        req_a   = bus.mem_addr;
        if (new_req) begin
            req_count++;
            check("req_addr", 64'(req_a), 64'(exp_pc));
            check("req_ctl", 64'({bus.mem_rw_flag[1], bus.mem_len, hold, pending}), 64'(5'b01100));
            exp_pc = exp_pc + 32'd4;
            if (catch_next) begin
                post_addr  = req_a;
                catch_next = 0;
            end
        end

        done_now = pending;
        r = drv_redir || (arm_req && new_req && req_a == arm_addr) || (arm_done && done_now);
        if (r) begin
            arm_req  = 0;
            arm_done = 0;
        end
        target = drv_rel ? model_ctrl_pc + drv_raddr : drv_raddr;
        bus.redirect_valid = r;
        bus.redirect_rel   = drv_rel;
        bus.redirect_addr  = drv_raddr;
        bus.mem_busy       = drv_busy;
        bus.dec_ready      = drv_ready;

        if (bus.dec_valid && drv_ready && !r && sb.size() != 0) begin
            head = sb.pop_front();
            check("deq", {bus.dec_pc, bus.dec_inst}, head);
        end

        if (done_now) begin
            d = inst_at(pend_addr);
            bus.mem_done = 1;
            bus.mem_read_data = d;
            if (!stale && !r) begin
                sb.push_back({pend_addr, d});
                if (is_ctrl_op(d)) begin
                    model_ctrl_pc = pend_addr;
                    hold = 1;
                end
            end
            pending = 0;
            stale   = 0;
        end else begin
            bus.mem_done = 0;
            bus.mem_read_data = 32'hDEAD_BEEF;
        end

        if (new_req) begin
            pending   = 1;
            pend_addr = req_a;
        end

        if (r) begin
            sb.delete();
            exp_pc = target;
            hold   = 0;
            if (pending) stale = 1;
            drv_redir  = 0;
            catch_next = 1;
            redir_count++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int unsigned rc0;
        drv_ready = 1; drv_busy = 0; drv_rel = 0; drv_raddr = '0;
        ctrl_en = 0; ctrl_at = 32'h8; arm_addr = '0; post_addr = '1;

        // sequential fetch, decoder always ready
        do_reset();
        repeat (30) cycle();
        check("t1_reqs", 64'(req_count >= 10), 64'(1));

        // decoder stalled: queue fills to depth, one dequeue frees one fetch
        drv_ready = 0;
        do_reset();
        repeat (20) cycle();
        check("t2_reqs", 64'(req_count), 64'(4));
        check("t2_full", 64'(bus.q_count), 64'(4));
        check("t2_head", 64'(bus.dec_pc), 64'(0));
        drv_ready = 1;
        cycle();
        drv_ready = 0;
        repeat (10) cycle();
        check("t2_reqs_after", 64'(req_count), 64'(5));
        check("t2_head_after", 64'(bus.dec_pc), 64'(4));

        // JAL at 0x8 stops fetch, relative redirect resumes at 0x28
        drv_ready = 1; ctrl_en = 1;
        do_reset();
        repeat (20) cycle();
        check("t3_reqs", 64'(req_count), 64'(3));
        post_addr = '1; drv_rel = 1; drv_raddr = 32'h20; drv_redir = 1;
        repeat (8) cycle();
        check("t3_target", 64'(post_addr), 64'(32'h28));
        ctrl_en = 0; drv_rel = 0;

        // redirect while the request to 0xC is outstanding
        do_reset();
        drv_raddr = 32'h100; arm_addr = 32'hC; arm_req = 1; post_addr = '1;
        repeat (20) cycle();
        check("t4_redir", 64'(redir_count), 64'(1));
        check("t4_target", 64'(post_addr), 64'(32'h100));

        // redirect coincident with mem_done and a decoder handshake
        drv_ready = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            if (bus.q_count == 2) break;
            cycle();
        end
        check("t5_fill", 64'(bus.q_count == 2 && pending), 64'(1));
        drv_ready = 1; arm_done = 1; drv_raddr = 32'h200; post_addr = '1;
        rc0 = redir_count;
        for (int i = 0; i < 10; i++) begin
            if (redir_count != rc0) break;
            cycle();
        end
        check("t5_redir", 64'(redir_count - rc0), 64'(1));
        cycle();
        check("t5_empty", 64'(bus.q_count), 64'(0));
        repeat (6) cycle();
        check("t5_target", 64'(post_addr), 64'(32'h200));

        // asynchronous reset mid-WAIT with three queued entries, late mem_done ignored
        drv_ready = 0;
        do_reset();
        for (int i = 0; i < 40; i++) begin
            if (bus.q_count == 3 && pending) break;
            cycle();
        end
        check("t6_fill", 64'(bus.q_count == 3 && pending), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        check("t6_rw", 64'(bus.mem_rw_flag), 64'(0));
        check("t6_addr", 64'(bus.mem_addr), 64'(0));
        check("t6_dec", {31'(0), bus.dec_valid, bus.dec_pc}, 64'(0));
        check("t6_inst", 64'(bus.dec_inst), 64'(0));
        check("t6_count", 64'(bus.q_count), 64'(0));
        bus.mem_done = 1; bus.mem_read_data = 32'h0000_0013;
        repeat (2) @(negedge clk);
        rst_n = 1'b1; bus.mem_busy = 1; bus.mem_done = 1;
        @(negedge clk);
        check("t6_late_done", {bus.mem_rw_flag, bus.dec_valid, 5'(bus.q_count)}, 64'(0));
        bus.mem_done = 0; bus.mem_busy = 0;
        model_reset();
        drv_ready = 1; drv_busy = 0; catch_next = 1; post_addr = '1;
        repeat (6) cycle();
        check("t6_first", 64'(post_addr), 64'(0));

        // random stalls, busy and redirects
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drv_ready = 1'($urandom_range(0, 1));
            drv_busy  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 19) == 0) begin
                drv_rel   = 1'($urandom_range(0, 1));
                drv_raddr = $urandom() & 32'hFFFF_FFFC;
                drv_redir = 1;
            end
            cycle();
        end
        check("t7_reqs", 64'(req_count > 20), 64'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fetch_queue_unit.md
Name: fetch_queue_unit

Overview:
- Parametrised next-generation instruction fetch unit. Sits between mem_ctrl and the Decoder.
- Issues sequential instruction reads and buffers returned instructions in a QUEUE_DEPTH-entry FIFO.
- Presents instructions to the Decoder with a valid/ready handshake.
- Handles absolute and PC-relative redirects, including flushing the queue and discarding stale in-flight responses.
- Optional legacy mode stops fetching after each control-flow instruction until a redirect arrives.

Parameters:
- ADDR_W, 32, address width.
- INST_W, 32, instruction width (≥7).
- QUEUE_DEPTH, 4, FIFO entries; power of two, ≥2.
- RESET_PC, 0, first fetch address after reset.
- STOP_ON_CTRL, 1, 1 = halt fetch after a control-flow instruction until redirect; 0 = keep fetching sequentially.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- mem_rw_flag  out  2  bit0 = read request, one-cycle pulse; bit1 always 0.
- mem_addr  out  ADDR_W  fetch address, valid while mem_rw_flag[0]=1.
- mem_len  out  2  constant 2'b11.
- mem_read_data  in  INST_W  returned instruction, valid when mem_done=1.
- mem_busy  in  1  mem_ctrl cannot accept a request.
- mem_done  in  1  one-cycle response strobe.
- redirect_valid  in  1  redirect pulse from ALU/branch unit.
- redirect_rel  in  1  1 = target is last_ctrl_pc + redirect_addr; 0 = target is redirect_addr.
- redirect_addr  in  ADDR_W  absolute target or offset.
- dec_valid  out  1  queue head is valid.
- dec_ready  in  1  Decoder accepts the head.
- dec_pc  out  ADDR_W  PC of the head instruction.
- dec_inst  out  INST_W  head instruction.
- q_count  out  $clog2(QUEUE_DEPTH)+1  current occupancy.

Behaviour:
- **Reset** (rst_n=0, asynchronous):
  - mem_rw_flag=0, mem_addr=0, dec_valid=0, dec_pc=0, dec_inst=0, q_count=0.
  - fetch_pc=RESET_PC, state=IDLE, discard=0, last_ctrl_pc=0.
  - A mem_done arriving after reset while in IDLE is ignored.
- **State IDLE → WAIT.** Issue when !mem_busy && q_count < QUEUE_DEPTH && !redirect_valid:
  - mem_rw_flag <= 2'b01, mem_addr <= fetch_pc, fetch_pc <= fetch_pc+4 (mod 2^ADDR_W).
  - Exactly one outstanding request at a time.
- **State WAIT, on mem_done with discard=0:**
  - Enqueue {mem_addr, mem_read_data}.
  - If STOP_ON_CTRL=1 and the opcode [6:0] is 1100011, 1101111, 1100111 or 0010111: last_ctrl_pc <= mem_addr, go to HOLD.
  - Otherwise, if the issue conditions hold (slot check uses the post-enqueue/dequeue count), issue the next request the same cycle and stay in WAIT; else go to IDLE.
  - With STOP_ON_CTRL=0, last_ctrl_pc still updates on control-flow opcodes.
- **State WAIT, on mem_done with discard=1:** drop the data, clear discard, go to IDLE.
- **State HOLD:** no requests until redirect_valid.
- **Redirect** (any state):
  - Compute target; redirect_rel uses last_ctrl_pc.
  - Flush the queue: q_count=0 and dec_valid=0 from the next cycle; a same-cycle dequeue is suppressed.
  - fetch_pc <= target.
  - If in WAIT without a same-cycle mem_done: discard <= 1, stay in WAIT. Otherwise go to IDLE.
  - Redirect in the same cycle as mem_done: the response is dropped.
  - The first request to the target is issued no earlier than the cycle after the redirect.
- **FIFO:**
  - Circular buffer with pointer wrap at QUEUE_DEPTH.
  - Dequeue when dec_valid && dec_ready. Simultaneous enqueue and dequeue keeps q_count unchanged, including when full.
  - dec_* reflect the head combinationally from registers; dec_pc/dec_inst hold stable while dec_valid && !dec_ready.
  - Never enqueue when full; this is guaranteed by the issue-time slot check.
- **Arithmetic:** all PC sums are ADDR_W-bit and wrap modulo 2^ADDR_W; no overflow flag.

Test Plan:
- Reset release, mem_busy=0, 1-cycle mem_done latency, dec_ready=1, non-control instructions → requests to 0x0, 0x4, 0x8, …; dec_pc follows the same sequence; q_count ≤ 1.
- dec_ready=0 with QUEUE_DEPTH=4 → exactly 4 requests; no 5th until one dequeue; q_count=4 held; head stable at PC 0x0.
- STOP_ON_CTRL=1, instruction at 0x8 = 0x0000006F (JAL) → no request after 0x8. Then redirect_rel=1, redirect_addr=0x20 → next request to 0x28.
- Redirect to 0x100 while a request to 0xC is outstanding → 0xC response dropped and never reaches dec; queue empty next cycle; next request 0x100.
- redirect_valid coincident with mem_done and dec_valid&&dec_ready → no enqueue, no dequeue; q_count=0; next request to target.
- rst_n asserted mid-WAIT with 3 queued entries → all outputs at reset values immediately; a late mem_done is ignored; first request after release to RESET_PC.
